mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the 5-stage MIPS pipeline. It consumes the M-stage signals held by the E-to-M pipeline register and performs the data-memory access. It services syscalls (print int, print char, exit) through a valid/ready console port, stalling upstream while a syscall is in progress. It also registers all results toward the W stage, so it contains the M-to-W pipeline register.

Parameters:
ADDR_W, 10, word-address width; data memory holds 2^ADDR_W 32-bit words
SYS_PRINT_INT, 1, v0 code for print integer
SYS_PRINT_CHAR, 11, v0 code for print character
SYS_EXIT, 10, v0 code for exit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
RegWriteM, MemtoRegM, MemWriteM, JalM, sysM  in  1 each  M-stage controls
ALUOutM  in  32  byte address / ALU result
WriteDataM  in  32  store data
WriteRegM  in  5  destination register
PCPlus4M  in  32  link value
regvM, regaM  in  32 each  $v0 and $a0 values at the syscall
StallM  out  1  upstream hold; E-to-M and earlier registers must not advance
RegWriteW, MemtoRegW, JalW  out  1 each  W-stage controls
ReadDataW, ALUOutW, PCPlus4W  out  32 each  W-stage data
WriteRegW  out  5  W-stage destination
con_valid  out  1  console data valid
con_type  out  1  0 = integer, 1 = character
con_data  out  32  console payload (char in [7:0], upper bits zero)
con_ready  in  1  console accepts the transfer
halted  out  1  exit syscall retired (sticky)
misalign  out  1  sticky: store or load to a non-word-aligned address

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; FSM goes to IDLE. Memory contents are not reset.
- Memory addressing: index = ALUOutM[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Stores: mem[index] <= WriteDataM at the rising edge when MemWriteM=1, ALUOutM[1:0]=0, state=IDLE and sysM=0.
- Misaligned store or load (MemWriteM or MemtoRegM, and ALUOutM[1:0]!=0): the write is suppressed and misalign is set to 1 until reset.
- Loads: ReadDataW <= mem[index] one cycle later. The read is read-before-write, so a same-edge store is not visible.
- M-to-W latency is 1 cycle. When neither the stall nor the bubble condition applies, all W outputs take the corresponding M inputs at each edge.
- Bubble: when sysM=1 or state!=IDLE, the next W outputs are RegWriteW=0, MemtoRegW=0, JalW=0 and all data fields 0. A syscall never writes a register.
- FSM states: IDLE, SEND, HALT.
  - IDLE, sysM=1, regvM=SYS_PRINT_INT or SYS_PRINT_CHAR: StallM=1 (combinational). The next state is SEND. On that edge, con_type and con_data are latched (con_data = regaM, or {24'b0, regaM[7:0]} for a character) and con_valid becomes 1.
  - IDLE, sysM=1, regvM=SYS_EXIT: StallM=1. The next state is HALT and halted becomes 1.
  - IDLE, sysM=1, any other regvM: treated as a nop. StallM=0 and the state stays IDLE.
  - SEND: con_valid=1, and con_data/con_type are held stable until the handshake. StallM = !con_ready. When con_ready=1, the transfer completes at that edge: con_valid goes to 0 and the next state is IDLE. Because StallM is 0 in that cycle, upstream advances and the syscall is consumed exactly once.
  - HALT: StallM=1 and halted=1 permanently, con_valid=0, and stores are suppressed. Only reset leaves HALT.
- Upstream must hold its M-stage inputs constant while StallM=1.
- Reset in SEND drops con_valid immediately and the pending character is discarded.

Test Plan:
- Store 0xDEADBEEF to 0x40, then load 0x40 -> ReadDataW=0xDEADBEEF one cycle after the load, with MemtoRegW=1 and WriteRegW echoed.
- Store 0x1 to 0x1000 with ADDR_W=10, then load 0x0 -> 0x1 (wrap-around). Store to 0x42 -> memory unchanged, misalign=1 and stays 1.
- sysM=1, regvM=1, regaM=-5, con_ready low for 3 cycles -> StallM high for 4 cycles total, con_data=0xFFFFFFFB stable while con_valid=1, exactly one handshake, then StallM=0.
- sysM=1, regvM=11, regaM=0x1234_0041 with con_ready=1 -> one stall cycle, con_data=0x41, con_type=1, con_valid high for exactly 1 cycle.
- sysM=1, regvM=10 -> halted=1 and StallM=1 forever, and a subsequent MemWriteM is ignored. Asserting rst_n=0 -> halted=0 and StallM=0 immediately.
- Drop rst_n mid-SEND -> con_valid goes to 0 asynchronously and all W outputs go to 0. Unknown v0 code 99 -> no stall and a bubble in W.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the M-stage inputs, the registered W-stage outputs, the
// upstream stall, the console valid/ready port and the sticky status flags of the
// MIPS memory stage.
//   master : upstream pipeline / console / environment side
//   slave  : mem_stage side
interface mem_stage_if;
   // M-stage inputs (held by the E-to-M register)
   logic        RegWriteM;
   logic        MemtoRegM;
   logic        MemWriteM;
   logic        JalM;
   logic        sysM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [4:0]  WriteRegM;
   logic [31:0] PCPlus4M;
   logic [31:0] regvM;
   logic [31:0] regaM;
   // Upstream hold
   logic        StallM;
   // W-stage outputs (M-to-W register)
   logic        RegWriteW;
   logic        MemtoRegW;
   logic        JalW;
   logic [31:0] ReadDataW;
   logic [31:0] ALUOutW;
   logic [31:0] PCPlus4W;
   logic [4:0]  WriteRegW;
   // Console port
   logic        con_valid;
   logic        con_type;
   logic [31:0] con_data;
   logic        con_ready;
   // Status
   logic        halted;
   logic        misalign;

   modport master (
      output RegWriteM, MemtoRegM, MemWriteM, JalM, sysM, ALUOutM, WriteDataM,
             WriteRegM, PCPlus4M, regvM, regaM, con_ready,
      input  StallM, RegWriteW, MemtoRegW, JalW, ReadDataW, ALUOutW, PCPlus4W,
             WriteRegW, con_valid, con_type, con_data, halted, misalign
   );

   modport slave (
      input  RegWriteM, MemtoRegM, MemWriteM, JalM, sysM, ALUOutM, WriteDataM,
             WriteRegM, PCPlus4M, regvM, regaM, con_ready,
      output StallM, RegWriteW, MemtoRegW, JalW, ReadDataW, ALUOutW, PCPlus4W,
             WriteRegW, con_valid, con_type, con_data, halted, misalign
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage. Performs the data-memory access, services the
// print-int / print-char / exit syscalls through a valid/ready console port while
// stalling upstream, and holds the M-to-W pipeline register.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_stage_if.slave (M inputs, W outputs, StallM, console, status)
module mem_stage #(
   parameter int unsigned ADDR_W         = 10,
   parameter logic [31:0] SYS_PRINT_INT  = 32'd1,
   parameter logic [31:0] SYS_PRINT_CHAR = 32'd11,
   parameter logic [31:0] SYS_EXIT       = 32'd10
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_stage_if.slave   bus
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [1:0] {StIdle, StSend, StHalt} state_e;

   state_e state_q, state_d;

   logic [31:0]       mem_q [Depth];
   logic [ADDR_W-1:0] index;
   logic              in_idle, bubble, aligned, instr_live;
   logic              is_print, is_char, is_exit;
   logic              mem_we, misalign_set, stall;

   logic        con_valid_q, con_valid_d;
   logic        con_type_q, con_type_d;
   logic [31:0] con_data_q, con_data_d;
   logic        halted_q, halted_d;
   logic        misalign_q;

   logic        regwrite_w_q, memtoreg_w_q, jal_w_q;
   logic [31:0] readdata_w_q, aluout_w_q, pcplus4_w_q;
   logic [4:0]  writereg_w_q;

   // Upper address bits are dropped, so the word index wraps modulo Depth.
   assign index   = bus.ALUOutM[ADDR_W+1:2];
   assign aligned = (bus.ALUOutM[1:0] == 2'b00);
   assign in_idle = (state_q == StIdle);
   // A syscall (known or not) or any non-idle state inserts a bubble toward W.
   assign bubble  = bus.sysM || !in_idle;
   // A real memory instruction sits in M only when idle and not a syscall.
   assign instr_live = in_idle && !bus.sysM;

   assign is_char  = (bus.regvM == SYS_PRINT_CHAR);
   assign is_print = bus.sysM && ((bus.regvM == SYS_PRINT_INT) || is_char);
   assign is_exit  = bus.sysM && (bus.regvM == SYS_EXIT);

   assign mem_we       = bus.MemWriteM && aligned && instr_live;
   assign misalign_set = (bus.MemWriteM || bus.MemtoRegM) && !aligned && instr_live;

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      con_valid_d = con_valid_q;
      con_type_d  = con_type_q;
      con_data_d  = con_data_q;
      halted_d    = halted_q;
      unique case (state_q)
         StIdle: begin
            if (is_print) begin
               stall       = 1'b1;
               state_d     = StSend;
               con_valid_d = 1'b1;
               con_type_d  = is_char;
               con_data_d  = is_char ? {24'b0, bus.regaM[7:0]} : bus.regaM;
            end else if (is_exit) begin
               stall    = 1'b1;
               state_d  = StHalt;
               halted_d = 1'b1;
            end
         end
         StSend: begin
            // Releasing the stall in the handshake cycle consumes the syscall once.
            stall = !bus.con_ready;
            if (bus.con_ready) begin
               con_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         StHalt: begin
            stall = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Gated by reset so StallM reads 0 while reset is held, whatever M presents.
   assign bus.StallM = rst_n & stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         con_valid_q <= 1'b0;
         con_type_q  <= 1'b0;
         con_data_q  <= 32'b0;
         halted_q    <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         con_valid_q <= con_valid_d;
         con_type_q  <= con_type_d;
         con_data_q  <= con_data_d;
         halted_q    <= halted_d;
         if (misalign_set) begin
            misalign_q <= 1'b1;
         end
      end
   end

   // M-to-W pipeline register; memory read is read-before-write by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwrite_w_q <= 1'b0;
         memtoreg_w_q <= 1'b0;
         jal_w_q      <= 1'b0;
         readdata_w_q <= 32'b0;
         aluout_w_q   <= 32'b0;
         pcplus4_w_q  <= 32'b0;
         writereg_w_q <= 5'b0;
      end else if (bubble) begin
         regwrite_w_q <= 1'b0;
         memtoreg_w_q <= 1'b0;
         jal_w_q      <= 1'b0;
         readdata_w_q <= 32'b0;
         aluout_w_q   <= 32'b0;
         pcplus4_w_q  <= 32'b0;
         writereg_w_q <= 5'b0;
      end else begin
         regwrite_w_q <= bus.RegWriteM;
         memtoreg_w_q <= bus.MemtoRegM;
         jal_w_q      <= bus.JalM;
         readdata_w_q <= mem_q[index];
         aluout_w_q   <= bus.ALUOutM;
         pcplus4_w_q  <= bus.PCPlus4M;
         writereg_w_q <= bus.WriteRegM;
      end
   end

   // Data memory array: contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[index] <= bus.WriteDataM;
      end
   end

   assign bus.RegWriteW = regwrite_w_q;
   assign bus.MemtoRegW = memtoreg_w_q;
   assign bus.JalW      = jal_w_q;
   assign bus.ReadDataW = readdata_w_q;
   assign bus.ALUOutW   = aluout_w_q;
   assign bus.PCPlus4W  = pcplus4_w_q;
   assign bus.WriteRegW = writereg_w_q;
   assign bus.con_valid = con_valid_q;
   assign bus.con_type  = con_type_q;
   assign bus.con_data  = con_data_q;
   assign bus.halted    = halted_q;
   assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage. Inputs are driven 1ns
// after the rising edge; StallM is sampled on the falling edge and registered
// outputs 1ns after the rising edge.
module tb_mem_stage;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mem_stage_if bus ();

   mem_stage #(
      .ADDR_W(10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.RegWriteM  = 1'b0;
      bus.MemtoRegM  = 1'b0;
      bus.MemWriteM  = 1'b0;
      bus.JalM       = 1'b0;
      bus.sysM       = 1'b0;
      bus.ALUOutM    = 32'h0;
      bus.WriteDataM = 32'h0;
      bus.WriteRegM  = 5'h0;
      bus.PCPlus4M   = 32'h0;
      bus.regvM      = 32'h0;
      bus.regaM      = 32'h0;
      bus.con_ready  = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
      clear_inputs();
      bus.MemWriteM  = 1'b1;
      bus.ALUOutM    = addr;
      bus.WriteDataM = data;
      tick();
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [4:0] rd);
      clear_inputs();
      bus.MemtoRegM = 1'b1;
      bus.RegWriteM = 1'b1;
      bus.ALUOutM   = addr;
      bus.WriteRegM = rd;
      bus.PCPlus4M  = 32'h0000_0104;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      clear_inputs();
      #12;
      n_checks++;
      if (bus.RegWriteW !== 1'b0 || bus.MemtoRegW !== 1'b0 || bus.JalW !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_w_ctrl: got %b%b%b required 000",
                  bus.RegWriteW, bus.MemtoRegW, bus.JalW);
      end
      n_checks++;
      if (bus.ReadDataW !== 32'h0 || bus.ALUOutW !== 32'h0 || bus.PCPlus4W !== 32'h0 ||
          bus.WriteRegW !== 5'h0) begin
         n_fail++;
         $display("FAIL reset_w_data: got %h %h %h %h required zeros",
                  bus.ReadDataW, bus.ALUOutW, bus.PCPlus4W, bus.WriteRegW);
      end
      n_checks++;
      if (bus.con_valid !== 1'b0 || bus.con_type !== 1'b0 || bus.con_data !== 32'h0 ||
          bus.halted !== 1'b0 || bus.misalign !== 1'b0 || bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_misc: got v%b t%b d%h h%b m%b s%b required all 0",
                  bus.con_valid, bus.con_type, bus.con_data, bus.halted, bus.misalign,
                  bus.StallM);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_store;
      do_store(32'h40, 32'hDEAD_BEEF);
      do_load(32'h40, 5'd5);
      n_checks++;
      if (bus.ReadDataW !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL load_data: got %h required deadbeef", bus.ReadDataW);
      end
      n_checks++;
      if (bus.MemtoRegW !== 1'b1 || bus.RegWriteW !== 1'b1 || bus.WriteRegW !== 5'd5) begin
         n_fail++;
         $display("FAIL load_ctrl: got m2r %b rw %b rd %0d required 1 1 5",
                  bus.MemtoRegW, bus.RegWriteW, bus.WriteRegW);
      end
      n_checks++;
      if (bus.ALUOutW !== 32'h40 || bus.PCPlus4W !== 32'h104) begin
         n_fail++;
         $display("FAIL load_pass: got alu %h pc4 %h required 40 104",
                  bus.ALUOutW, bus.PCPlus4W);
      end
      // Read-before-write on the same edge
      do_store(32'h44, 32'hAAAA_0000);
      clear_inputs();
      bus.MemWriteM  = 1'b1;
      bus.MemtoRegM  = 1'b1;
      bus.ALUOutM    = 32'h44;
      bus.WriteDataM = 32'hBBBB_0000;
      tick();
      n_checks++;
      if (bus.ReadDataW !== 32'hAAAA_0000) begin
         n_fail++;
         $display("FAIL read_before_write: got %h required aaaa0000", bus.ReadDataW);
      end
      do_load(32'h44, 5'd6);
      n_checks++;
      if (bus.ReadDataW !== 32'hBBBB_0000) begin
         n_fail++;
         $display("FAIL load_after_write: got %h required bbbb0000", bus.ReadDataW);
      end
      clear_inputs();
      bus.JalM     = 1'b1;
      bus.PCPlus4M = 32'h0000_2008;
      tick();
      n_checks++;
      if (bus.JalW !== 1'b1 || bus.PCPlus4W !== 32'h2008 || bus.MemtoRegW !== 1'b0) begin
         n_fail++;
         $display("FAIL jal_pass: got jal %b pc4 %h m2r %b required 1 2008 0",
                  bus.JalW, bus.PCPlus4W, bus.MemtoRegW);
      end
   endtask

   task automatic test_wrap;
      do_store(32'h1000, 32'h0000_0001);
      do_load(32'h0, 5'd7);
      n_checks++;
      if (bus.ReadDataW !== 32'h1) begin
         n_fail++;
         $display("FAIL wrap_load: got %h required 00000001", bus.ReadDataW);
      end
      n_checks++;
      if (bus.misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_clean: got %b required 0", bus.misalign);
      end
   endtask

   task automatic test_misalign;
      do_store(32'h42, 32'h0000_0099);
      n_checks++;
      if (bus.misalign !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_set: got %b required 1", bus.misalign);
      end
      do_load(32'h40, 5'd8);
      n_checks++;
      if (bus.ReadDataW !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL misalign_suppress: got %h required deadbeef", bus.ReadDataW);
      end
      clear_inputs();
      tick();
      tick();
      n_checks++;
      if (bus.misalign !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_sticky: got %b required 1", bus.misalign);
      end
   endtask

   task automatic test_print_int;
      int stall_cnt;
      int hs_cnt;
      stall_cnt = 0;
      hs_cnt    = 0;
      clear_inputs();
      bus.sysM      = 1'b1;
      bus.regvM     = 32'd1;
      bus.regaM     = 32'hFFFF_FFFB;
      bus.RegWriteM = 1'b1;
      bus.WriteRegM = 5'd2;
      bus.ALUOutM   = 32'h80;
      @(negedge clk);
      if (bus.StallM === 1'b1) stall_cnt++;
      n_checks++;
      if (bus.con_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pint_pre_valid: got %b required 0", bus.con_valid);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.StallM === 1'b1) stall_cnt++;
         if (bus.con_valid === 1'b1 && bus.con_ready === 1'b1) hs_cnt++;
         n_checks++;
         if (bus.con_valid !== 1'b1 || bus.con_data !== 32'hFFFF_FFFB ||
             bus.con_type !== 1'b0) begin
            n_fail++;
            $display("FAIL pint_hold%0d: got v%b t%b d%h required v1 t0 dfffffffb",
                     k, bus.con_valid, bus.con_type, bus.con_data);
         end
         n_checks++;
         if (bus.RegWriteW !== 1'b0 || bus.WriteRegW !== 5'd0) begin
            n_fail++;
            $display("FAIL pint_bubble%0d: got rw %b rd %0d required 0 0",
                     k, bus.RegWriteW, bus.WriteRegW);
         end
         tick();
      end
      bus.con_ready = 1'b1;
      @(negedge clk);
      if (bus.StallM === 1'b1) stall_cnt++;
      if (bus.con_valid === 1'b1 && bus.con_ready === 1'b1) hs_cnt++;
      n_checks++;
      if (bus.con_data !== 32'hFFFF_FFFB) begin
         n_fail++;
         $display("FAIL pint_hs_data: got %h required fffffffb", bus.con_data);
      end
      tick();
      clear_inputs();
      @(negedge clk);
      if (bus.StallM === 1'b1) stall_cnt++;
      if (bus.con_valid === 1'b1 && bus.con_ready === 1'b1) hs_cnt++;
      n_checks++;
      if (stall_cnt !== 4) begin
         n_fail++;
         $display("FAIL pint_stall_cycles: got %0d required 4", stall_cnt);
      end
      n_checks++;
      if (hs_cnt !== 1) begin
         n_fail++;
         $display("FAIL pint_handshakes: got %0d required 1", hs_cnt);
      end
      n_checks++;
      if (bus.con_valid !== 1'b0 || bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL pint_done: got v%b s%b required v0 s0", bus.con_valid, bus.StallM);
      end
      tick();
   endtask

   task automatic test_print_char;
      clear_inputs();
      bus.sysM      = 1'b1;
      bus.regvM     = 32'd11;
      bus.regaM     = 32'h1234_0041;
      bus.con_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.StallM !== 1'b1) begin
         n_fail++;
         $display("FAIL pchar_stall: got %b required 1", bus.StallM);
      end
      tick();
      n_checks++;
      if (bus.con_valid !== 1'b1 || bus.con_type !== 1'b1 || bus.con_data !== 32'h41) begin
         n_fail++;
         $display("FAIL pchar_send: got v%b t%b d%h required v1 t1 d00000041",
                  bus.con_valid, bus.con_type, bus.con_data);
      end
      @(negedge clk);
      n_checks++;
      if (bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL pchar_release: got %b required 0", bus.StallM);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (bus.con_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pchar_one_cycle: got %b required 0", bus.con_valid);
      end
      tick();
   endtask

   task automatic test_unknown_sys;
      clear_inputs();
      bus.sysM      = 1'b1;
      bus.regvM     = 32'd99;
      bus.RegWriteM = 1'b1;
      bus.WriteRegM = 5'd7;
      bus.ALUOutM   = 32'h123;
      @(negedge clk);
      n_checks++;
      if (bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL unk_stall: got %b required 0", bus.StallM);
      end
      tick();
      n_checks++;
      if (bus.RegWriteW !== 1'b0 || bus.WriteRegW !== 5'd0 || bus.ALUOutW !== 32'h0 ||
          bus.con_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL unk_bubble: got rw %b rd %0d alu %h v%b required 0 0 0 0",
                  bus.RegWriteW, bus.WriteRegW, bus.ALUOutW, bus.con_valid);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_send_reset;
      clear_inputs();
      bus.sysM  = 1'b1;
      bus.regvM = 32'd1;
      bus.regaM = 32'd7;
      tick();
      n_checks++;
      if (bus.con_valid !== 1'b1 || bus.con_data !== 32'd7) begin
         n_fail++;
         $display("FAIL sreset_pre: got v%b d%h required v1 d00000007",
                  bus.con_valid, bus.con_data);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.con_valid !== 1'b0 || bus.StallM !== 1'b0 || bus.con_data !== 32'h0) begin
         n_fail++;
         $display("FAIL sreset_async: got v%b s%b d%h required 0 0 0",
                  bus.con_valid, bus.StallM, bus.con_data);
      end
      n_checks++;
      if (bus.RegWriteW !== 1'b0 || bus.ReadDataW !== 32'h0 || bus.ALUOutW !== 32'h0 ||
          bus.PCPlus4W !== 32'h0 || bus.WriteRegW !== 5'h0) begin
         n_fail++;
         $display("FAIL sreset_w: got %b %h %h %h %h required zeros", bus.RegWriteW,
                  bus.ReadDataW, bus.ALUOutW, bus.PCPlus4W, bus.WriteRegW);
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.con_valid !== 1'b0 || bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL sreset_discard: got v%b s%b required 0 0", bus.con_valid, bus.StallM);
      end
   endtask

   task automatic test_exit;
      clear_inputs();
      bus.sysM  = 1'b1;
      bus.regvM = 32'd10;
      @(negedge clk);
      n_checks++;
      if (bus.StallM !== 1'b1) begin
         n_fail++;
         $display("FAIL exit_stall: got %b required 1", bus.StallM);
      end
      tick();
      n_checks++;
      if (bus.halted !== 1'b1) begin
         n_fail++;
         $display("FAIL exit_halted: got %b required 1", bus.halted);
      end
      do_store(32'h40, 32'h5555_5555);
      tick();
      n_checks++;
      if (bus.halted !== 1'b1 || bus.StallM !== 1'b1 || bus.RegWriteW !== 1'b0 ||
          bus.con_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL exit_hold: got h%b s%b rw%b v%b required 1 1 0 0",
                  bus.halted, bus.StallM, bus.RegWriteW, bus.con_valid);
      end
      clear_inputs();
      bus.sysM  = 1'b1;
      bus.regvM = 32'd10;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.halted !== 1'b0 || bus.StallM !== 1'b0) begin
         n_fail++;
         $display("FAIL exit_reset: got h%b s%b required 0 0", bus.halted, bus.StallM);
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      bus.MemtoRegM = 1'b1;
      bus.RegWriteM = 1'b1;
      bus.ALUOutM   = 32'h40;
      bus.WriteRegM = 5'd9;
      tick();
      n_checks++;
      if (bus.ReadDataW !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL exit_store_ignored: got %h required deadbeef", bus.ReadDataW);
      end
      clear_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_load_store();
      test_wrap();
      test_misalign();
      test_print_int();
      test_print_char();
      test_unknown_sys();
      test_send_reset();
      test_exit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
